// File: rtl/rast_pkg.sv
// Shared rasterizer front-end types: fixed-point triangle and colour payloads.
// Coordinates are signed, colours unsigned; both carry SIGFIG bits.
package rast_pkg;
   localparam int SIGFIG     = 24;
   localparam int VERTS      = 3;
   localparam int AXIS       = 3;
   localparam int COLORS     = 3;
   localparam int FIFO_DEPTH = 4;

   typedef logic signed [SIGFIG-1:0] coord_t;
   typedef coord_t [VERTS-1:0][AXIS-1:0] tri_t;
   typedef logic [SIGFIG-1:0] chan_t;
   typedef chan_t [COLORS-1:0] color_t;

   typedef struct packed {
      tri_t   tri_v;
      color_t color;
   } tri_entry_t;

   // One extra bit so a full FIFO is distinguishable from an empty one.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/tri_ingress_buffer_if.sv
// R10 (source side) and R11 (bbox side) triangle handshake bundle.
// master is the environment around the buffer, slave is the buffer itself.
interface tri_ingress_buffer_if
   import rast_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
);
   localparam int CNT_W = cnt_w(DEPTH);

   tri_t             tri_R10S;
   color_t           color_R10U;
   logic             validTri_R10H;
   logic             halt_RnnnnL;
   tri_t             tri_R11S;
   color_t           color_R11U;
   logic             validTri_R11H;
   logic             halt_ds_RnnnnL;
   logic [CNT_W-1:0] occupancy_R11U;
   logic [31:0]      tri_count_R11U;

   modport master (
      output tri_R10S, color_R10U, validTri_R10H, halt_ds_RnnnnL,
      input  halt_RnnnnL, tri_R11S, color_R11U, validTri_R11H,
             occupancy_R11U, tri_count_R11U
   );

   modport slave (
      input  tri_R10S, color_R10U, validTri_R10H, halt_ds_RnnnnL,
      output halt_RnnnnL, tri_R11S, color_R11U, validTri_R11H,
             occupancy_R11U, tri_count_R11U
   );
endinterface

// File: rtl/rast_fifo_mem.sv
// Triangle storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the owner tracks validity.
module rast_fifo_mem
   import rast_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  tri_entry_t    wdata,
   input  logic [AW-1:0] raddr,
   output tri_entry_t    rdata
);
   tri_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/tri_ingress_buffer.sv
// Rasterizer ingress FIFO: R10 triangles in, R11 head out one cycle after a push into empty.
// halt_RnnnnL drops only when DEPTH entries are held; halt_ds_RnnnnL low freezes the head.
module tri_ingress_buffer
   import rast_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input logic                 clk,
   input logic                 rst,
   tri_ingress_buffer_if.slave bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [CNT_W-1:0] count;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [31:0]      tri_count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   tri_entry_t       wdata;
   tri_entry_t       rdata;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.validTri_R10H & ~full;
   assign pop   = ~empty & bus.halt_ds_RnnnnL;

   assign wdata.tri_v = bus.tri_R10S;
   assign wdata.color = bus.color_R10U;

   rast_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tri_count <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + AW'(1);
            tri_count <= tri_count + 32'd1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.halt_RnnnnL    = ~full;
   assign bus.validTri_R11H  = ~empty;
   assign bus.occupancy_R11U = count;
   assign bus.tri_count_R11U = tri_count;
   // Unreset storage must never leak out, so the head is masked while empty.
   assign bus.tri_R11S       = empty ? '0 : rdata.tri_v;
   assign bus.color_R11U     = empty ? '0 : rdata.color;

`ifndef SYNTHESIS
   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.validTri_R11H && !bus.halt_ds_RnnnnL) |=>
         ($stable(bus.tri_R11S) && $stable(bus.color_R11U)));
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CNT_W'(DEPTH));
`endif
endmodule

// File: tb/tb_tri_ingress_buffer.sv
// Bench for tri_ingress_buffer: queue-based reference model checked every cycle,
// plus directed literal checks for reset, single, fill, streaming, random stall and wrap.
module tb_tri_ingress_buffer;
   import rast_pkg::*;

   localparam int DEPTH = FIFO_DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b1;

   tri_ingress_buffer_if #(.DEPTH(DEPTH)) ifc ();

   tri_ingress_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model: a plain queue of accepted triangles.
   tri_entry_t  mq[$];
   logic [31:0] m_cnt  = '0;
   bit          m_push = 1'b0;
   bit          mp, mo;

   // Source-side stimulus state.
   tri_entry_t pend[$];
   int         stall_pct = 0;
   int         gap_pct   = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_cnt  = '0;
         m_push = 1'b0;
      end else begin
         mp = ifc.validTri_R10H && (mq.size() < DEPTH);
         mo = (mq.size() > 0) && ifc.halt_ds_RnnnnL;
         if (mo) void'(mq.pop_front());
         if (mp) begin
            mq.push_back('{tri_v: ifc.tri_R10S, color: ifc.color_R10U});
            m_cnt = m_cnt + 32'd1;
         end
         m_push = mp;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_entry(input string nm, input tri_entry_t act, input tri_entry_t exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      tri_entry_t got, exp;
      if (!rst) begin
         got = '{tri_v: ifc.tri_R11S, color: ifc.color_R11U};
         exp = (mq.size() > 0) ? mq[0] : '0;
         chk("cyc_valid", longint'(ifc.validTri_R11H), longint'(mq.size() != 0));
         chk("cyc_halt", longint'(ifc.halt_RnnnnL), longint'(mq.size() != DEPTH));
         chk("cyc_occupancy", longint'(ifc.occupancy_R11U), longint'(mq.size()));
         chk("cyc_tri_count", longint'(ifc.tri_count_R11U), longint'(m_cnt));
         chk_entry("cyc_head_data", got, exp);
      end
   end

   function automatic tri_entry_t rnd_entry();
      tri_entry_t e;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            e.tri_v[v][a] = coord_t'($urandom);
      for (int c = 0; c < COLORS; c++)
         e.color[c] = chan_t'($urandom);
      return e;
   endfunction

   // One clock of source/sink behaviour: hold an offered triangle until accepted.
   task automatic step();
      @(posedge clk);
      #1;
      if (m_push && pend.size() > 0) void'(pend.pop_front());
      if (ifc.validTri_R10H && !m_push && pend.size() > 0) begin
         ifc.validTri_R10H = 1'b1;
      end else if (pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
         ifc.validTri_R10H = 1'b1;
         ifc.tri_R10S      = pend[0].tri_v;
         ifc.color_R10U    = pend[0].color;
      end else begin
         ifc.validTri_R10H = 1'b0;
      end
      ifc.halt_ds_RnnnnL = ($urandom_range(99) >= stall_pct);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while ((pend.size() > 0 || mq.size() > 0 || ifc.validTri_R10H) && n < budget) begin
         step();
         n++;
      end
      vectors++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: drain not done after %0d cycles, %0d queued", nm, n, mq.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      pend.delete();
      ifc.validTri_R10H = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      steps(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tri_entry_t lit;
      ifc.tri_R10S       = '0;
      ifc.color_R10U     = '0;
      ifc.validTri_R10H  = 1'b0;
      ifc.halt_ds_RnnnnL = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", ifc.validTri_R11H, 0);
      chk("reset_halt", ifc.halt_RnnnnL, 1);
      chk("reset_occupancy", ifc.occupancy_R11U, 0);
      chk("reset_tri_count", ifc.tri_count_R11U, 0);

      // Single triangle, v0=(1.0,2.0,0.5) in Q.10, colour (0x3FF,0,0).
      lit = '0;
      lit.tri_v[0][0] = 24'sd1024;
      lit.tri_v[0][1] = 24'sd2048;
      lit.tri_v[0][2] = 24'sd512;
      lit.tri_v[1][0] = 24'sd3072;
      lit.tri_v[1][1] = -24'sd1024;
      lit.tri_v[2][2] = 24'sd256;
      lit.color[0]    = 24'h3FF;
      stall_pct = 0;
      gap_pct   = 0;
      pend.push_back(lit);
      steps(2);
      @(negedge clk);
      chk("single_valid", ifc.validTri_R11H, 1);
      chk_entry("single_data", '{tri_v: ifc.tri_R11S, color: ifc.color_R11U}, lit);
      chk("single_occupancy", ifc.occupancy_R11U, 1);
      step();
      @(negedge clk);
      chk("single_popped_occ", ifc.occupancy_R11U, 0);
      chk("single_popped_valid", ifc.validTri_R11H, 0);

      // Fill against a stalled bbox: 4 accepted, 2 held at the source.
      do_reset();
      stall_pct = 100;
      for (int i = 0; i < 6; i++) pend.push_back(rnd_entry());
      steps(8);
      @(negedge clk);
      chk("fill_halt", ifc.halt_RnnnnL, 0);
      chk("fill_occupancy", ifc.occupancy_R11U, 4);
      chk("fill_tri_count", ifc.tri_count_R11U, 4);
      stall_pct = 0;
      drain("fill_drain", 50);
      @(negedge clk);
      chk("fill_total", ifc.tri_count_R11U, 6);
      chk("fill_empty", ifc.occupancy_R11U, 0);

      // Reset with 3 entries held: outputs go to reset values without a clock edge.
      stall_pct = 100;
      for (int i = 0; i < 3; i++) pend.push_back(rnd_entry());
      steps(6);
      @(negedge clk);
      chk("prereset_occupancy", ifc.occupancy_R11U, 3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      pend.delete();
      ifc.validTri_R10H = 1'b0;
      #1;
      chk("midreset_valid", ifc.validTri_R11H, 0);
      chk("midreset_occupancy", ifc.occupancy_R11U, 0);
      chk("midreset_halt", ifc.halt_RnnnnL, 1);
      chk("midreset_tri_count", ifc.tri_count_R11U, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall_pct = 0;
      steps(2);

      // Streaming at one triangle per cycle.
      for (int i = 0; i < 100; i++) pend.push_back(rnd_entry());
      steps(50);
      @(negedge clk);
      chk("stream_mid_occupancy", ifc.occupancy_R11U, 1);
      steps(51);
      @(negedge clk);
      chk("stream_tri_count", ifc.tri_count_R11U, 100);
      chk("stream_occupancy", ifc.occupancy_R11U, 1);
      step();
      @(negedge clk);
      chk("stream_done", ifc.occupancy_R11U, 0);

      // Random stalls and source gaps.
      do_reset();
      stall_pct = 30;
      gap_pct   = 30;
      for (int i = 0; i < 1000; i++) pend.push_back(rnd_entry());
      drain("random_drain", 20000);
      @(negedge clk);
      chk("random_tri_count", ifc.tri_count_R11U, 1000);
      chk("random_empty", ifc.occupancy_R11U, 0);

      // Pointer wrap: occupancy toggles 0 <-> DEPTH.
      do_reset();
      gap_pct = 0;
      for (int r = 0; r < 2 * DEPTH + 1; r++) begin
         stall_pct = 100;
         for (int i = 0; i < DEPTH; i++) pend.push_back(rnd_entry());
         steps(6);
         @(negedge clk);
         chk("wrap_full_occ", ifc.occupancy_R11U, DEPTH);
         chk("wrap_full_halt", ifc.halt_RnnnnL, 0);
         stall_pct = 0;
         steps(6);
         @(negedge clk);
         chk("wrap_empty_occ", ifc.occupancy_R11U, 0);
      end
      chk("wrap_tri_count", ifc.tri_count_R11U, (2 * DEPTH + 1) * DEPTH);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
